// File: rtl/clock_display_ctrl.sv
// 1 Hz timekeeping in BCD with set buttons, HH:MM / SS view FSM and 12/24 h presentation.
// Define AUTOREPEAT_EN to make held set buttons repeat after one second.
module clock_display_ctrl #(
    parameter int unsigned CLK_HZ         = 8192,
    parameter int unsigned REVERT_SECONDS = 3,
    parameter int unsigned REPEAT_DIV     = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_hr_i,
    input  logic        inc_min_i,
    input  logic        disp_sel_i,
    input  logic        mode12_i,
    output logic [15:0] disp_o,
    output logic        colon_o,
    output logic        pm_o,
    output logic        tick_o,
    output logic        view_o
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned RW = $clog2(REVERT_SECONDS + 1);
    localparam logic [PW-1:0] PRESC_MAX   = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF  = PW'(CLK_HZ / 2);
    localparam logic [RW-1:0] REVERT_LOAD = RW'(REVERT_SECONDS);

    typedef enum logic [0:0] {StHm, StSs} view_e;

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    sec_q, sec_d, min_q, min_d, hr_q, hr_d;
    logic          inc_hr_q, inc_min_q, disp_sel_q, mode12_q;
    view_e         view_q, view_d;
    logic [RW-1:0] revert_q, revert_d;
    logic          tick, ev_hr, ev_min, sel_ev, set_ev;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v == max_v) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

`ifdef AUTOREPEAT_EN
    localparam int unsigned HW = $clog2(CLK_HZ + 1);
    localparam logic [HW-1:0] HOLD_FIRE   = HW'(CLK_HZ);
    // Reloading here puts the next repeat CLK_HZ/REPEAT_DIV cycles after this one.
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(CLK_HZ - CLK_HZ / REPEAT_DIV + 1);

    logic [HW-1:0] hold_hr_q, hold_hr_d, hold_min_q, hold_min_d;
    logic          rep_hr, rep_min;

    always_comb begin
        rep_hr     = inc_hr_i && (hold_hr_q == HOLD_FIRE);
        rep_min    = inc_min_i && (hold_min_q == HOLD_FIRE);
        hold_hr_d  = '0;
        hold_min_d = '0;
        if (inc_hr_i) hold_hr_d = rep_hr ? HOLD_RELOAD : hold_hr_q + 1'b1;
        if (inc_min_i) hold_min_d = rep_min ? HOLD_RELOAD : hold_min_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_hr_q  <= '0;
            hold_min_q <= '0;
        end else begin
            hold_hr_q  <= hold_hr_d;
            hold_min_q <= hold_min_d;
        end
    end

    assign ev_hr  = (inc_hr_i & ~inc_hr_q) | rep_hr;
    assign ev_min = (inc_min_i & ~inc_min_q) | rep_min;
`else
    assign ev_hr  = inc_hr_i & ~inc_hr_q;
    assign ev_min = inc_min_i & ~inc_min_q;
`endif

    assign tick   = (presc_q == PRESC_MAX);
    assign sel_ev = disp_sel_i & ~disp_sel_q;
    assign set_ev = ev_hr | ev_min;

    // A set event wins over a coincident tick, discarding its carries.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        if (set_ev) begin
            presc_d = '0;
            sec_d   = 8'h00;
            if (ev_min) min_d = bcd_inc(min_q, 8'h59);
            if (ev_hr) hr_d = bcd_inc(hr_q, 8'h23);
        end else if (tick) begin
            sec_d = bcd_inc(sec_q, 8'h59);
            if (sec_q == 8'h59) begin
                min_d = bcd_inc(min_q, 8'h59);
                if (min_q == 8'h59) hr_d = bcd_inc(hr_q, 8'h23);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q    <= '0;
            sec_q      <= 8'h00;
            min_q      <= 8'h00;
            hr_q       <= 8'h00;
            inc_hr_q   <= 1'b0;
            inc_min_q  <= 1'b0;
            disp_sel_q <= 1'b0;
            mode12_q   <= 1'b0;
            view_q     <= StHm;
            revert_q   <= '0;
        end else begin
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hr_q       <= hr_d;
            inc_hr_q   <= inc_hr_i;
            inc_min_q  <= inc_min_i;
            disp_sel_q <= disp_sel_i;
            mode12_q   <= mode12_i;
            view_q     <= view_d;
            revert_q   <= revert_d;
        end
    end

    always_comb begin
        view_d   = view_q;
        revert_d = revert_q;
        case (view_q)
            StHm: begin
                if (!set_ev && sel_ev) begin
                    view_d   = StSs;
                    revert_d = REVERT_LOAD;
                end
            end
            StSs: begin
                if (set_ev) begin
                    view_d = StHm;
                end else if (sel_ev) begin
                    revert_d = REVERT_LOAD;
                end else if (tick) begin
                    if (revert_q == RW'(1)) view_d = StHm;
                    else revert_d = revert_q - 1'b1;
                end
            end
            default: view_d = StHm;
        endcase
    end

    logic [4:0] hr_bin, hr_disp;
    logic [3:0] hr_tens, hr_ones;

    always_comb begin
        hr_bin = {1'b0, hr_q[7:4]} * 5'd10 + {1'b0, hr_q[3:0]};
        if (!mode12_q) hr_disp = hr_bin;
        else if (hr_bin == 5'd0) hr_disp = 5'd12;
        else if (hr_bin > 5'd12) hr_disp = hr_bin - 5'd12;
        else hr_disp = hr_bin;

        if (hr_disp >= 5'd20) begin
            hr_tens = 4'd2;
            hr_ones = 4'(hr_disp - 5'd20);
        end else if (hr_disp >= 5'd10) begin
            hr_tens = 4'd1;
            hr_ones = 4'(hr_disp - 5'd10);
        end else begin
            hr_tens = 4'd0;
            hr_ones = hr_disp[3:0];
        end

        pm_o   = (hr_bin >= 5'd12);
        tick_o = tick;
        view_o = (view_q == StSs);
        if (view_q == StSs) begin
            disp_o  = {8'hAA, sec_q};
            colon_o = 1'b1;
        end else begin
            disp_o  = {(mode12_q && hr_tens == 4'd0) ? 4'hA : hr_tens, hr_ones, min_q};
            colon_o = (presc_q < PRESC_HALF);
        end
    end

endmodule

// File: tb/tb_clock_display_ctrl.sv
// Randomised and directed bench for clock_display_ctrl against a seconds-of-day model.
module tb_clock_display_ctrl;

    localparam int CLK = 16;
    localparam int REV = 3;
    localparam int RP  = 4;
    localparam int PER = CLK / RP;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        inc_hr = 1'b0, inc_min = 1'b0, disp_sel = 1'b0, mode12 = 1'b0;
    logic [15:0] disp;
    logic        colon, pm, tick, view;

    always #5 clk = ~clk;

    clock_display_ctrl #(
        .CLK_HZ(CLK),
        .REVERT_SECONDS(REV),
        .REPEAT_DIV(RP)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .inc_hr_i(inc_hr),
        .inc_min_i(inc_min),
        .disp_sel_i(disp_sel),
        .mode12_i(mode12),
        .disp_o(disp),
        .colon_o(colon),
        .pm_o(pm),
        .tick_o(tick),
        .view_o(view)
    );

    int errors = 0, checks = 0;
    int m_presc, m_sec, m_min, m_hr, m_view, m_rev, m_m12, m_phr, m_pmin, m_psel;
    int m_age_hr, m_age_min;
    int tick_cnt = 0, view_cnt = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_disp();
        int h;
        logic [3:0] d3;
        if (m_view != 0) return {8'hAA, 4'(m_sec / 10), 4'(m_sec % 10)};
        h = (m_m12 != 0) ? ((m_hr % 12 == 0) ? 12 : m_hr % 12) : m_hr;
        d3 = (m_m12 != 0 && h < 10) ? 4'hA : 4'(h / 10);
        return {d3, 4'(h % 10), 4'(m_min / 10), 4'(m_min % 10)};
    endfunction

    function automatic logic exp_colon();
        return (m_view != 0) ? 1'b1 : (m_presc < CLK / 2);
    endfunction

    task automatic model_reset();
        m_presc = 0; m_sec = 0; m_min = 0; m_hr = 0; m_view = 0; m_rev = 0; m_m12 = 0;
        m_phr = 0; m_pmin = 0; m_psel = 0; m_age_hr = 0; m_age_min = 0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic m_step();
        bit ehr, emin, esel, tk, set;
        int t;
        tk   = (m_presc == CLK - 1);
        ehr  = inc_hr && (m_phr == 0);
        emin = inc_min && (m_pmin == 0);
        esel = disp_sel && (m_psel == 0);
`ifdef AUTOREPEAT_EN
        m_age_hr  = inc_hr ? (ehr ? 0 : m_age_hr + 1) : 0;
        m_age_min = inc_min ? (emin ? 0 : m_age_min + 1) : 0;
        if (inc_hr && m_age_hr >= CLK && (m_age_hr - CLK) % PER == 0) ehr = 1'b1;
        if (inc_min && m_age_min >= CLK && (m_age_min - CLK) % PER == 0) emin = 1'b1;
`endif
        set = ehr || emin;
        if (set) begin
            m_presc = 0;
            m_sec = 0;
            if (emin) m_min = (m_min + 1) % 60;
            if (ehr) m_hr = (m_hr + 1) % 24;
            m_view = 0;
        end else begin
            m_presc = (m_presc + 1) % CLK;
            if (tk) begin
                t = (m_hr * 3600 + m_min * 60 + m_sec + 1) % 86400;
                m_hr = t / 3600; m_min = (t / 60) % 60; m_sec = t % 60;
            end
            if (esel) begin
                m_view = 1; m_rev = REV;
            end else if (m_view != 0 && tk) begin
                if (m_rev == 1) m_view = 0;
                else m_rev--;
            end
        end
        m_m12 = mode12; m_phr = inc_hr; m_pmin = inc_min; m_psel = disp_sel;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("disp", disp, exp_disp());
            check("colon", 16'(colon), 16'(exp_colon()));
            check("pm", 16'(pm), 16'(m_hr >= 12));
            check("tick", 16'(tick), 16'(m_presc == CLK - 1));
            check("view", 16'(view), 16'(m_view));
        end
    end

    task automatic cycle();
        @(negedge clk);
        if (tick) tick_cnt++;
        if (view) view_cnt++;
        @(posedge clk);
        if (!rst_ni) model_reset();
        else m_step();
        #1;
    endtask

    task automatic pulse(input int which);
        if (which == 0) inc_hr = 1'b1;
        else if (which == 1) inc_min = 1'b1;
        else disp_sel = 1'b1;
        cycle();
        inc_hr = 1'b0; inc_min = 1'b0; disp_sel = 1'b0;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hsave, m0, inc, mexp, guard;
        model_reset();
        repeat (3) cycle();
        check("rst_disp", disp, 16'h0000);
        check("rst_colon", 16'(colon), 16'd1);
        check("rst_pm", 16'(pm), 16'd0);
        check("rst_tick", 16'(tick), 16'd0);
        check("rst_view", 16'(view), 16'd0);
        rst_ni = 1'b1;
        chk_en = 1'b1;

        tick_cnt = 0;
        repeat (60 * CLK) cycle();
        check("ticks_60s", 16'(tick_cnt), 16'd60);
        check("disp_1min", disp, 16'h0001);

        repeat (23) pulse(0);
        for (int i = 0; i < 60 && m_min != 59; i++) pulse(1);
        check("preload", disp, 16'h2359);
        repeat (59 * CLK) cycle();
        check("pm_2359", 16'(pm), 16'd1);
        repeat (CLK) cycle();
        check("midnight", disp, 16'h0000);
        check("pm_0000", 16'(pm), 16'd0);

        mode12 = 1'b1;
        repeat (13) pulse(0);
        check("h12_13", disp, 16'hA100);
        check("pm_13", 16'(pm), 16'd1);
        repeat (11) pulse(0);
        check("h12_0", disp, 16'h1200);
        check("pm_0", 16'(pm), 16'd0);
        mode12 = 1'b0;

        pulse(1);
        guard = 0;
        while (!(m_sec == 7 && m_presc == 0) && guard < 20 * CLK) begin cycle(); guard++; end
        check("sync_sec7", 16'(guard < 20 * CLK), 16'd1);
        view_cnt = 0;
        disp_sel = 1'b1; cycle(); disp_sel = 1'b0;
        check("ss_disp", disp, 16'hAA07);
        check("ss_colon", 16'(colon), 16'd1);
        repeat (3 * CLK + 8) cycle();
        check("ss_len", 16'(view_cnt), 16'(3 * CLK - 1));

        guard = 0;
        while (m_presc != 0 && guard < 2 * CLK) begin cycle(); guard++; end
        view_cnt = 0;
        disp_sel = 1'b1; cycle(); disp_sel = 1'b0;
        repeat (2 * CLK - 1) cycle();
        disp_sel = 1'b1; cycle(); disp_sel = 1'b0;
        repeat (3 * CLK + 8) cycle();
        check("ss_ext_len", 16'(view_cnt), 16'(5 * CLK - 1));

        for (int i = 0; i < 60 && m_min != 59; i++) pulse(1);
        guard = 0;
        while (m_presc != CLK - 1 && guard < 2 * CLK) begin cycle(); guard++; end
        hsave = m_hr;
        check("tick_cycle", 16'(tick), 16'd1);
        inc_min = 1'b1; cycle(); inc_min = 1'b0;
        check("min_wrap", disp, 16'((hsave / 10) * 4096 + (hsave % 10) * 256));
        check("presc_clr", 16'(tick), 16'd0);
        disp_sel = 1'b1; cycle(); disp_sel = 1'b0;
        check("sec_clr", disp, 16'hAA00);

        m0 = m_min;
`ifdef AUTOREPEAT_EN
        inc = 1 + 2 * RP;
`else
        inc = 1;
`endif
        inc_min = 1'b1;
        repeat (3 * CLK) cycle();
        inc_min = 1'b0;
        cycle();
        mexp = (m0 + inc) % 60;
        check("hold_min", 16'(disp[7:0]), 16'((mexp / 10) * 16 + mexp % 10));

        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                rst_ni = 1'b0;
                model_reset();
                #1;
                check("async_rst_disp", disp, 16'h0000);
                check("async_rst_view", 16'(view), 16'd0);
                cycle(); cycle();
                rst_ni = 1'b1;
            end
            if ($urandom_range(0, 99) < 4) inc_hr = ~inc_hr;
            if ($urandom_range(0, 99) < 4) inc_min = ~inc_min;
            if ($urandom_range(0, 99) < 6) disp_sel = ~disp_sel;
            if ($urandom_range(0, 99) < 1) mode12 = ~mode12;
            cycle();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_display_ctrl.md
# clock_display_ctrl

Parametrised timekeeping and display-mode controller for the 4-digit 7-segment clock; the successor to the fixed 8.192 kHz clock top. It divides the system clock to 1 Hz, keeps hours/minutes/seconds in BCD, and applies set buttons with edge detection and optional auto-repeat. It also runs the HH:MM / SS display state machine with a timed revert, and supports 12/24-hour presentation. Its digit/colon outputs feed the 7-segment encoder and the 595 shift-register serializer downstream.

## Interface
- CLK_HZ, 8192: system clock frequency; prescaler counts 0..CLK_HZ-1 (width $clog2(CLK_HZ))
- REVERT_SECONDS, 3: whole seconds SS view stays up before returning to HH:MM (>=1)
- REPEAT_DIV, 4: auto-repeat increments per second (used only with AUTOREPEAT_EN)

- clk_i  in  1  system clock; sole clock
- rst_ni  in  1  asynchronous, active-low reset
- inc_hr_i  in  1  debounced hour-set level, active high
- inc_min_i  in  1  debounced minute-set level, active high
- disp_sel_i  in  1  debounced view-select level, active high
- mode12_i  in  1  1 = 12-hour presentation, 0 = 24-hour; quasi-static
- disp_o  out  16  four BCD nibbles, [15:12] leftmost digit; 4'hA = blank
- colon_o  out  1  colon segment enable
- pm_o  out  1  1 when internal hour >= 12 (valid in both modes)
- tick_o  out  1  one-cycle pulse on each 1 Hz prescaler wrap
- view_o  out  1  0 = HH:MM view, 1 = SS view

## Operation
- Reset (async assert, sync release): prescaler 0, time 00:00:00, view HH:MM, revert 0, edge-detect regs 0. Outputs: disp_o 16'h0000, colon_o 1, pm_o 0, tick_o 0, view_o 0.
- Prescaler: increments every cycle; at CLK_HZ-1 wraps to 0 and asserts tick_o that cycle.
- Time is kept internally in 24-hour BCD. On tick:
  - sec +1; 59 -> 00 carries to min.
  - min 59 -> 00 carries to hr.
  - hr 23 -> 00.
- Set events are rising edges of inc_hr_i or inc_min_i, each detected against a registered copy.
  - Minute set: min +1, 59 -> 00 with no carry to hour.
  - Hour set: hr +1, 23 -> 00.
  - Any set event clears sec to 00 and the prescaler to 0. A tick in the same cycle is discarded, including its carries.
  - Both set events in the same cycle: both fields increment.
- View FSM, states HM and SS:
  - HM -> SS on a disp_sel_i rising edge; revert loads REVERT_SECONDS.
  - In SS, a disp_sel_i edge reloads revert.
  - In SS, each tick decrements revert. A tick with revert == 1 -> HM.
  - A set event in SS -> HM immediately.
- HM presentation:
  - 24 h: hr tens, hr ones, min tens, min ones.
  - 12 h: hr 0 -> 12, 13..23 -> 1..11. A zero hour-tens digit shows blank.
  - colon_o = 1 while prescaler < CLK_HZ/2, else 0 (blinks at 1 Hz).
- SS presentation: blank, blank, sec tens, sec ones; colon_o steady 1.

## Timing
- All state is updated on posedge clk_i. disp_o, colon_o, pm_o and view_o are combinational from registers only, with no input-to-output paths.
- Button edge at cycle N: register updates at N+1 edge; output reflects it in cycle N+1.
- tick_o is high in the cycle the prescaler equals CLK_HZ-1. Time changes on the following edge.
- Buttons are asynchronous to nothing here; the debouncer upstream is synchronous to clk_i.
- Reset asserted mid-operation: all state clears immediately, independent of clk_i.

## Configuration
- AUTOREPEAT_EN defined: a set button held continuously for CLK_HZ cycles after its rising edge generates further set events.
  - Repeat events occur every CLK_HZ/REPEAT_DIV cycles while the button is held.
  - Each repeat has full set-event semantics (clears sec and prescaler, forces HM).
  - The hold counter is per button and clears on release.
- AUTOREPEAT_EN undefined: only rising edges count; hold counters and REPEAT_DIV logic are absent.

## Test plan
- Reset, run 60*CLK_HZ cycles -> disp_o 16'h0001, tick_o pulsed 60 times, colon toggles every CLK_HZ/2 cycles.
- Preload to 23:59:59 via 23 hour edges and 59 minute edges, then run 59 s; one more tick -> 00:00:00, pm_o 1 -> 0.
- Set mode12_i=1 and hour to 13 -> disp_o 16'hA100, pm_o 1; at hour 0 -> 16'h1200, pm_o 0.
- disp_sel_i pulse at sec 07 -> disp_o 16'hAA07, colon_o 1. Reverts to HM exactly on the 3rd tick. A second pulse after 2 s extends the SS view to 5 s total.
- Assert inc_min_i in the same cycle as tick_o with min=59 -> min 00, hr unchanged, sec 00, prescaler 0.
- AUTOREPEAT_EN: hold inc_min_i for 3*CLK_HZ cycles -> 1 + 2*REPEAT_DIV = 9 increments; without the macro -> 1 increment.
